// File: rtl/gpi_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : gpi_debounce
//  Description : Two-flop synchronizer plus per-bit tick-qualified debouncer
//                with registered rise/fall event pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpi_debounce #(
    parameter int W        = 8,
    parameter int TICK_DIV = 100000,
    parameter int STABLE   = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din_raw,
    output logic [W-1:0] db_out,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE + 1);

    localparam logic [PW-1:0] C_PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(STABLE - 1);

    logic [W-1:0]         s1_q;
    logic [W-1:0]         s2_q;
    logic [PW-1:0]        pre_q;
    logic [PW-1:0]        pre_d;
    logic                 tick;
    logic [W-1:0][CW-1:0] cnt_q;
    logic [W-1:0][CW-1:0] cnt_d;
    logic [W-1:0]         db_q;
    logic [W-1:0]         db_d;
    logic [W-1:0]         rise_q;
    logic [W-1:0]         rise_d;
    logic [W-1:0]         fall_q;
    logic [W-1:0]         fall_d;

    // Free-running prescaler shared by every bit.
    always_comb begin
        tick  = (pre_q == C_PRE_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
    end

    // A bit matching its debounced level clears its counter on any cycle,
    // so a single-cycle return to the old level restarts qualification.
    always_comb begin
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < W; i++) begin
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == C_CNT_LAST) begin
                    db_d[i]   = s2_q[i];
                    cnt_d[i]  = '0;
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            pre_q  <= '0;
            cnt_q  <= '0;
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            s1_q   <= din_raw;
            s2_q   <= s1_q;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign db_out = db_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_gpi_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpi_debounce
//  Description : Randomized and directed bench for gpi_debounce with a
//                cycle-count based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpi_debounce;

    localparam int W        = 4;
    localparam int TICK_DIV = 4;
    localparam int STABLE   = 3;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] din_raw;
    logic [W-1:0] db_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    gpi_debounce #(
        .W        (W),
        .TICK_DIV (TICK_DIV),
        .STABLE   (STABLE)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .din_raw (din_raw),
        .db_out  (db_out),
        .rise    (rise),
        .fall    (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference model: k counts clock edges since reset release; ticks fall on
    // edges where k mod TICK_DIV == TICK_DIV-1. A bit flips on the tick that
    // completes STABLE ticks inside its current uninterrupted mismatch run.
    int           k;
    logic [W-1:0] m_s1, m_s2, m_db, m_rise, m_fall;
    int           run_start [W];

    int           rise_pulses [W];
    int           fall_pulses [W];
    int           rise_all_a;
    logic [W-1:0] db_or;
    logic         bad_mid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        m_s1   = '0;
        m_s2   = '0;
        m_db   = '0;
        m_rise = '0;
        m_fall = '0;
        for (int b = 0; b < W; b++) run_start[b] = -1;
    endtask

    task automatic model_edge(input logic [W-1:0] d, input logic r);
        bit tk;
        int nticks;
        if (!r) begin
            model_reset();
            return;
        end
        tk     = ((k % TICK_DIV) == TICK_DIV - 1);
        m_rise = '0;
        m_fall = '0;
        for (int b = 0; b < W; b++) begin
            if (m_s2[b] != m_db[b]) begin
                if (run_start[b] < 0) run_start[b] = k;
                nticks = (k + 1) / TICK_DIV - run_start[b] / TICK_DIV;
                if (tk && nticks >= STABLE) begin
                    m_db[b]      = m_s2[b];
                    m_rise[b]    = m_s2[b];
                    m_fall[b]    = ~m_s2[b];
                    run_start[b] = -1;
                end
            end else begin
                run_start[b] = -1;
            end
        end
        m_s2 = m_s1;
        m_s1 = d;
        k++;
    endtask

    task automatic clear_stats();
        for (int b = 0; b < W; b++) begin
            rise_pulses[b] = 0;
            fall_pulses[b] = 0;
        end
        rise_all_a = 0;
        db_or      = '0;
        bad_mid    = 1'b0;
    endtask

    task automatic step();
        logic [W-1:0] d;
        logic         r;
        d = din_raw;
        r = reset_n;
        @(posedge clk);
        #1;
        model_edge(d, r);
        chk("db_out", 32'(db_out), 32'(m_db));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        for (int b = 0; b < W; b++) begin
            if (rise[b]) rise_pulses[b]++;
            if (fall[b]) fall_pulses[b]++;
        end
        if (rise == 4'hA) rise_all_a++;
        if (db_out != 4'h0 && db_out != 4'hA) bad_mid = 1'b1;
        db_or = db_or | db_out;
    endtask

    task automatic wait_db(input logic [W-1:0] mask, input logic [W-1:0] val,
                           input int maxc, output int n);
        n = 0;
        while (((db_out & mask) != val) && n < maxc) begin
            step();
            n++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int           n;
    int           rate;
    logic [W-1:0] nd;

    initial begin
        model_reset();
        clear_stats();
        reset_n = 1'b0;
        din_raw = 4'hF;
        #1;
        chk("rst_db", 32'(db_out), 0);
        chk("rst_rise", 32'(rise), 0);
        chk("rst_fall", 32'(fall), 0);
        for (int c = 0; c < 5; c++) step();

        // Reset release with inputs held high.
        reset_n = 1'b1;
        clear_stats();
        wait_db(4'hF, 4'hF, 20, n);
        chk("rel_lat_ok", 32'(n >= 1 && n <= 14), 1);
        for (int c = 0; c < 4; c++) step();
        chk("rel_rise_cnt", 32'(rise_pulses[0] + rise_pulses[3]), 2);
        chk("rel_fall_cnt", 32'(fall_pulses[0] + fall_pulses[1] + fall_pulses[2] + fall_pulses[3]), 0);

        din_raw = 4'h0;
        wait_db(4'hF, 4'h0, 20, n);
        chk("clr_lat_ok", 32'(n <= 14), 1);
        for (int c = 0; c < 5; c++) step();

        // Clean press on bit0.
        clear_stats();
        din_raw = 4'h1;
        wait_db(4'h1, 4'h1, 20, n);
        chk("press_lat_ok", 32'(n >= 11 && n <= 14), 1);
        chk("press_rise_now", 32'(rise[0]), 1);
        for (int c = n; c < 40; c++) step();
        chk("press_rise_cnt", 32'(rise_pulses[0]), 1);
        chk("press_hi_bits", 32'(db_out[3:1]), 0);

        // Release of bit0.
        clear_stats();
        din_raw = 4'h0;
        wait_db(4'h1, 4'h0, 20, n);
        chk("release_lat_ok", 32'(n >= 11 && n <= 14), 1);
        for (int c = 0; c < 6; c++) step();
        chk("release_fall_cnt", 32'(fall_pulses[0]), 1);
        chk("release_rise_cnt", 32'(rise_pulses[0] + rise_pulses[1] + rise_pulses[2] + rise_pulses[3]), 0);

        // Bounce on bit1.
        clear_stats();
        for (int r = 0; r < 5; r++) begin
            din_raw = 4'h2;
            for (int c = 0; c < 6; c++) step();
            din_raw = 4'h0;
            for (int c = 0; c < 3; c++) step();
        end
        for (int c = 0; c < 20; c++) step();
        chk("bounce_db1", 32'(db_or[1]), 0);
        chk("bounce_rise1", 32'(rise_pulses[1]), 0);

        // Simultaneous bits.
        clear_stats();
        din_raw = 4'hA;
        wait_db(4'hF, 4'hA, 20, n);
        chk("simul_lat_ok", 32'(n >= 11 && n <= 14), 1);
        chk("simul_rise_now", 32'(rise), 32'hA);
        for (int c = 0; c < 4; c++) step();
        chk("simul_rise_cnt", 32'(rise_all_a), 1);
        chk("simul_one_step", 32'(bad_mid), 0);
        din_raw = 4'h0;
        wait_db(4'hF, 4'h0, 20, n);
        chk("simul_clr_ok", 32'(n <= 14), 1);
        for (int c = 0; c < 5; c++) step();

        // Reset mid-qualification on bit2.
        din_raw = 4'h4;
        for (int c = 0; c < 8; c++) step();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rmq_db", 32'(db_out), 0);
        step();
        reset_n = 1'b1;
        wait_db(4'h4, 4'h4, 20, n);
        chk("rmq_lat", 32'(n), 12);
        chk("rmq_rise_now", 32'(rise), 32'h4);

        // Reset while the rise pulse is high.
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("rmp_rise", 32'(rise), 0);
        chk("rmp_db", 32'(db_out), 0);
        step();
        reset_n = 1'b1;
        din_raw = 4'h0;
        for (int c = 0; c < 10; c++) step();

        // Randomized: alternating glitchy and quiet phases, occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rate = (((c / 200) % 2) == 0) ? 30 : 2;
            nd = din_raw;
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 99) < rate) nd[b] = ~nd[b];
            end
            din_raw = nd;
            if ($urandom_range(0, 699) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                chk("rnd_rst_db", 32'(db_out), 0);
                chk("rnd_rst_pulse", 32'(rise | fall), 0);
                step();
                reset_n = 1'b1;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
